// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/bubble/vector
// constants, the next-PC select encoding and the IF/ID payload bundle.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR  = 32'h0000_0000;   // sll $0,$0,0
    localparam logic [31:0] IF_IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] IF_EXC_VECTOR = 32'h8000_0008;

    // Which source produced the PC loaded on the last edge.
    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        HOLD  = 2'd1,
        REDIR = 2'd2,
        VEC   = 2'd3
    } pc_sel_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // Instruction addresses are word aligned; drop the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble request beats a stall; a stall freezes
// every field; otherwise the freshly fetched word is captured as valid.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_pc_plus4_i,
    input  logic [31:0] fetch_instr_i,
    output if_id_t      id_o
);

    if_id_t id_q;
    if_id_t id_d;

    // Next IF/ID contents: bubble > hold > capture.
    always_comb begin
        id_d = id_q;
        if (flush_i) begin
            // PC fields still track the fetch address so a debugger can see
            // where the squashed slot came from.
            id_d.valid    = 1'b0;
            id_d.pc       = fetch_pc_i;
            id_d.pc_plus4 = fetch_pc_plus4_i;
            id_d.instr    = NOP_INSTR;
        end else if (!stall_i) begin
            id_d.valid    = 1'b1;
            id_d.pc       = fetch_pc_i;
            id_d.pc_plus4 = fetch_pc_plus4_i;
            id_d.instr    = fetch_instr_i;
        end
    end

    // IF/ID storage; reset leaves a NOP bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q.valid    <= 1'b0;
            id_q.pc       <= 32'h0;
            id_q.pc_plus4 <= 32'h0;
            id_q.instr    <= NOP_INSTR;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_o = id_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address and feeds the IF/ID register.
// Optional interrupt/exception vectoring is enabled by IF_STAGE_IRQ_EXC_EN.
// pc_sel_o exposes the registered next-PC source for debug only.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = IF_NOP_INSTR
`ifdef IF_STAGE_IRQ_EXC_EN
    ,
    parameter logic [31:0] IRQ_VECTOR = IF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR = IF_EXC_VECTOR
`endif
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic [31:0] id_instr_o,
`ifdef IF_STAGE_IRQ_EXC_EN
    input  logic        irq_i,
    input  logic        exc_i,
    output logic [31:0] epc_o,
    output logic        epc_we_o,
`endif
    output pc_sel_e     pc_sel_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    pc_sel_e     sel_q;
    pc_sel_e     sel_d;
    logic        bubble;
    if_id_t      id_q;

`ifdef IF_STAGE_IRQ_EXC_EN
    logic [31:0] epc_q;
    logic [31:0] epc_d;
    logic        epc_we_q;
    logic        epc_we_d;
`endif

    assign pc_plus4     = pc_q + 32'd4;     // wraps modulo 2^32
    assign redirect_tgt = word_align(redirect_pc_i);
    assign imem_addr_o  = pc_q;             // zero-latency fetch

    // Next-PC selection: [exc > irq >] redirect > stall > sequential.
    always_comb begin
        pc_d   = pc_plus4;
        sel_d  = SEQ;
        bubble = flush_i;
`ifdef IF_STAGE_IRQ_EXC_EN
        epc_d    = epc_q;
        epc_we_d = 1'b0;
        if (exc_i) begin
            // Return past the faulting instruction sitting in ID.
            pc_d     = EXC_VECTOR;
            sel_d    = VEC;
            bubble   = 1'b1;
            epc_d    = id_q.pc + 32'd4;
            epc_we_d = 1'b1;
        end else if (irq_i && !pc_q[31]) begin
            // User mode only; a pending redirect is the true resume point.
            pc_d     = IRQ_VECTOR;
            sel_d    = VEC;
            bubble   = 1'b1;
            epc_d    = redirect_valid_i ? redirect_tgt : pc_q;
            epc_we_d = 1'b1;
        end else
`endif
        if (redirect_valid_i) begin
            // The older instruction in EX wins over a younger load-use stall.
            pc_d   = redirect_tgt;
            sel_d  = REDIR;
            bubble = 1'b1;
        end else if (stall_i) begin
            pc_d  = pc_q;
            sel_d = HOLD;
        end
    end

    // PC and debug select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            sel_q <= SEQ;
        end else begin
            pc_q  <= pc_d;
            sel_q <= sel_d;
        end
    end

`ifdef IF_STAGE_IRQ_EXC_EN
    // Exception PC capture and its one-cycle write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q    <= 32'h0;
            epc_we_q <= 1'b0;
        end else begin
            epc_q    <= epc_d;
            epc_we_q <= epc_we_d;
        end
    end

    assign epc_o    = epc_q;
    assign epc_we_o = epc_we_q;
`endif

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (bubble),
        .fetch_pc_i       (pc_q),
        .fetch_pc_plus4_i (pc_plus4),
        .fetch_instr_i    (imem_instr_i),
        .id_o             (id_q)
    );

    assign id_valid_o    = id_q.valid;
    assign id_pc_o       = id_q.pc;
    assign id_pc_plus4_o = id_q.pc_plus4;
    assign id_instr_o    = id_q.instr;
    assign pc_sel_o      = sel_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vectors, a behavioural fetch model checked
// every cycle, and literal expectations at the interesting points.
`timescale 1ns/1ps
module tb_if_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic [31:0] id_instr_o;
    pc_sel_e     pc_sel_o;
`ifdef IF_STAGE_IRQ_EXC_EN
    logic        irq_i = 1'b0;
    logic        exc_i = 1'b0;
    logic [31:0] epc_o;
    logic        epc_we_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents: the test-plan program, then a recognisable
    // address-tagged pattern everywhere else.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h8c06_0000;
            32'h4:   return 32'h8c04_0004;
            32'h8:   return 32'h2005_0008;
            32'hC:   return 32'h0c10_0006;
            default: return {16'h2400, a[15:0]} ^ {a[31:16], 16'h0};
        endcase
    endfunction

    assign imem_instr_i = imem_word(imem_addr_o);

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .id_valid_o       (id_valid_o),
        .id_pc_o          (id_pc_o),
        .id_pc_plus4_o    (id_pc_plus4_o),
        .id_instr_o       (id_instr_o),
`ifdef IF_STAGE_IRQ_EXC_EN
        .irq_i            (irq_i),
        .exc_i            (exc_i),
        .epc_o            (epc_o),
        .epc_we_o         (epc_we_o),
`endif
        .pc_sel_o         (pc_sel_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_idpc, m_idp4, m_instr, m_epc;
    logic        m_valid, m_epcwe;
    pc_sel_e     m_sel;

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_idpc = 32'h0; m_idp4 = 32'h0;
        m_instr = 32'h0; m_epc = 32'h0; m_epcwe = 1'b0; m_sel = SEQ;
    endtask

    task automatic model_edge();
        logic [31:0] tgt, nxt;
        logic        vec, squash;
        tgt = {redirect_pc_i[31:2], 2'b00};
        vec = 1'b0;
        m_epcwe = 1'b0;
`ifdef IF_STAGE_IRQ_EXC_EN
        if (exc_i) begin
            vec = 1'b1; nxt = 32'h8000_0008; m_epc = m_idpc + 32'd4; m_epcwe = 1'b1;
        end else if (irq_i && m_pc < 32'h8000_0000) begin
            vec = 1'b1; nxt = 32'h8000_0004;
            m_epc = redirect_valid_i ? tgt : m_pc; m_epcwe = 1'b1;
        end
`endif
        if (vec)                   m_sel = VEC;
        else if (redirect_valid_i) m_sel = REDIR;
        else if (stall_i)          m_sel = HOLD;
        else                       m_sel = SEQ;
        if (!vec) nxt = redirect_valid_i ? tgt : (stall_i ? m_pc : m_pc + 32'd4);
        squash = vec || redirect_valid_i || flush_i;
        if (squash) begin
            m_valid = 1'b0; m_idpc = m_pc; m_idp4 = m_pc + 32'd4; m_instr = 32'h0;
        end else if (!stall_i) begin
            m_valid = 1'b1; m_idpc = m_pc; m_idp4 = m_pc + 32'd4; m_instr = imem_word(m_pc);
        end
        m_pc = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                chk("m_imem_addr", imem_addr_o, m_pc);
                chk("m_id_valid", {31'h0, id_valid_o}, {31'h0, m_valid});
                chk("m_id_pc", id_pc_o, m_idpc);
                chk("m_id_pc_plus4", id_pc_plus4_o, m_idp4);
                chk("m_id_instr", id_instr_o, m_instr);
                chk("m_pc_sel", {30'h0, pc_sel_o}, {30'h0, m_sel});
`ifdef IF_STAGE_IRQ_EXC_EN
                chk("m_epc", epc_o, m_epc);
                chk("m_epc_we", {31'h0, epc_we_o}, {31'h0, m_epcwe});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
`ifdef IF_STAGE_IRQ_EXC_EN
        irq_i = 1'b0; exc_i = 1'b0;
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_imem_addr"}, imem_addr_o, 32'h0);
        chk({tag, "_id_valid"}, {31'h0, id_valid_o}, 32'h0);
        chk({tag, "_id_pc"}, id_pc_o, 32'h0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4_o, 32'h0);
        chk({tag, "_id_instr"}, id_instr_o, 32'h0);
`ifdef IF_STAGE_IRQ_EXC_EN
        chk({tag, "_epc"}, epc_o, 32'h0);
        chk({tag, "_epc_we"}, {31'h0, epc_we_o}, 32'h0);
`endif
    endtask

    // Watchdog: the run is purely time-driven, but never allow a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #8;
        chk_reset_state("reset");
        #4 rst_n = 1'b1;
        chk_en = 1'b1;

        // Free-running fetch of the first four words.
        tick();
        chk("seq1_addr", imem_addr_o, 32'h4);
        chk("seq1_valid", {31'h0, id_valid_o}, 32'h1);
        chk("seq1_instr", id_instr_o, 32'h8c06_0000);
        chk("seq1_pc", id_pc_o, 32'h0);
        tick();
        chk("seq2_instr", id_instr_o, 32'h8c04_0004);
        chk("seq2_pc", id_pc_o, 32'h4);
        tick();
        chk("seq3_instr", id_instr_o, 32'h2005_0008);
        chk("seq3_pc", id_pc_o, 32'h8);
        tick();
        chk("seq4_addr", imem_addr_o, 32'h10);
        chk("seq4_instr", id_instr_o, 32'h0c10_0006);

        // Two-cycle stall at pc=0x10.
        stall_i = 1'b1;
        tick();
        chk("stall1_addr", imem_addr_o, 32'h10);
        chk("stall1_pc", id_pc_o, 32'hC);
        tick();
        chk("stall2_addr", imem_addr_o, 32'h10);
        chk("stall2_instr", id_instr_o, 32'h0c10_0006);
        stall_i = 1'b0;
        tick();
        chk("resume_addr", imem_addr_o, 32'h14);
        chk("resume_pc", id_pc_o, 32'h10);

        // Redirect overrides a simultaneous stall and bubbles IF/ID.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0098; stall_i = 1'b1;
        tick();
        chk("redir_addr", imem_addr_o, 32'h98);
        chk("redir_valid", {31'h0, id_valid_o}, 32'h0);
        chk("redir_instr", id_instr_o, 32'h0);
        chk("redir_dbg_pc", id_pc_o, 32'h14);
        chk("redir_sel", {30'h0, pc_sel_o}, {30'h0, REDIR});
        clear_inputs();
        tick();
        chk("post_redir_pc", id_pc_o, 32'h98);

        // Misaligned redirect target is word aligned.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0043;
        tick();
        chk("align_addr", imem_addr_o, 32'h40);
        clear_inputs();

        // Flush alone advances; flush with stall holds PC but still bubbles.
        flush_i = 1'b1;
        tick();
        chk("flush_addr", imem_addr_o, 32'h44);
        chk("flush_valid", {31'h0, id_valid_o}, 32'h0);
        stall_i = 1'b1;
        tick();
        chk("flushstall_addr", imem_addr_o, 32'h44);
        chk("flushstall_valid", {31'h0, id_valid_o}, 32'h0);
        chk("flushstall_pc", id_pc_o, 32'h44);
        clear_inputs();
        tick();

        // PC wrap-around at the top of the address space.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre_addr", imem_addr_o, 32'hFFFF_FFFC);
        clear_inputs();
        tick();
        chk("wrap_addr", imem_addr_o, 32'h0);
        chk("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", id_pc_plus4_o, 32'h0);

        // Asynchronous reset mid-cycle at pc=0x58.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h58;
        tick();
        clear_inputs();
        chk("pre_arst_addr", imem_addr_o, 32'h58);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("arst");
        #3 rst_n = 1'b1;
        tick();
        chk("restart_addr", imem_addr_o, 32'h4);
        chk("restart_pc", id_pc_o, 32'h0);
        chk("restart_valid", {31'h0, id_valid_o}, 32'h1);

`ifdef IF_STAGE_IRQ_EXC_EN
        // Interrupt in user mode, then a repeated request in kernel mode.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h24;
        tick();
        clear_inputs();
        irq_i = 1'b1;
        tick();
        chk("irq_addr", imem_addr_o, 32'h8000_0004);
        chk("irq_epc", epc_o, 32'h24);
        chk("irq_epc_we", {31'h0, epc_we_o}, 32'h1);
        chk("irq_valid", {31'h0, id_valid_o}, 32'h0);
        tick();
        chk("irq_kern_addr", imem_addr_o, 32'h8000_0008);
        chk("irq_kern_epc_we", {31'h0, epc_we_o}, 32'h0);
        irq_i = 1'b0; exc_i = 1'b1; stall_i = 1'b1;
        tick();
        chk("exc_addr", imem_addr_o, 32'h8000_0008);
        chk("exc_epc", epc_o, 32'h8000_0008);
        chk("exc_epc_we", {31'h0, epc_we_o}, 32'h1);
        clear_inputs();
        tick();
        chk("exc_epc_we_drop", {31'h0, epc_we_o}, 32'h0);
`endif

        // Mixed control traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 40; i++) begin
            stall_i          = ($urandom_range(0, 3) == 0);
            flush_i          = ($urandom_range(0, 5) == 0);
            redirect_valid_i = ($urandom_range(0, 6) == 0);
            redirect_pc_i    = $urandom;
            tick();
        end
        clear_inputs();
        tick();
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
